// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one radix-2 step per clock, Moore outputs.
// Optional build macro MULDIV_EARLY_OUT_EN: a zero operand skips the iteration loop.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            Start_MD,
  input  logic            Flush_MD,
  input  logic [2:0]      Funct3_MD,
  input  logic [XLEN-1:0] Rs1_MD,
  input  logic [XLEN-1:0] Rs2_MD,
  input  logic [4:0]      Rd_MD,
  output logic            Busy_MD,
  output logic            WrEn_MD,
  output logic [4:0]      WAddr_MD,
  output logic [XLEN-1:0] WD_MD
);

  // state | meaning
  // IDLE  | waiting for Start_MD
  // CALC  | XLEN shift-add / shift-subtract steps
  // SIGN  | sign fix-up, result select, load write-back registers
  // DONE  | one-cycle write-back strobe
  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t r_state, w_next;

  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_funct3;
  logic [4:0]       r_rd;
  logic [XLEN-1:0]  r_a, r_b, r_hi, r_lo;
  logic             r_neg_a, r_neg_b;
  logic [XLEN-1:0]  r_wd;
  logic [4:0]       r_waddr;

  logic            w_is_div, w_sgn_a, w_sgn_b, w_neg_a, w_neg_b;
  logic [XLEN-1:0] w_mag_a, w_mag_b;
  logic            w_start, w_last, w_early;

  assign w_is_div = Funct3_MD[2];
  assign w_sgn_a  = (Funct3_MD == 3'd1) || (Funct3_MD == 3'd2) ||
                    (Funct3_MD == 3'd4) || (Funct3_MD == 3'd6);
  assign w_sgn_b  = (Funct3_MD == 3'd1) || (Funct3_MD == 3'd4) || (Funct3_MD == 3'd6);
  assign w_neg_a  = w_sgn_a & Rs1_MD[XLEN-1];
  assign w_neg_b  = w_sgn_b & Rs2_MD[XLEN-1];
  assign w_mag_a  = w_neg_a ? -Rs1_MD : Rs1_MD;
  assign w_mag_b  = w_neg_b ? -Rs2_MD : Rs2_MD;
  assign w_start  = (r_state == IDLE) && Start_MD && !Flush_MD;
  assign w_last   = (r_cnt == CNT_W'(XLEN-1));

`ifdef MULDIV_EARLY_OUT_EN
  assign w_early = (Rs1_MD == '0) || (Rs2_MD == '0);
`else
  assign w_early = 1'b0;
`endif

  // Iteration datapath: r_hi:r_lo is the product accumulator for multiplies,
  // and remainder:dividend/quotient shift pair for divides.
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_rem_sh;
  logic              w_ge;
  logic [XLEN-1:0]   w_sub;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo, w_rem, w_res;

  assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
  assign w_rem_sh = {r_hi, r_lo[XLEN-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_b});
  assign w_sub    = w_rem_sh[XLEN-1:0] - r_b;

  assign w_prod = (r_neg_a ^ r_neg_b) ? -{r_hi, r_lo} : {r_hi, r_lo};
  // Divide by zero keeps the all-ones quotient unsigned-style, whatever the dividend sign.
  assign w_quo  = (r_b == '0) ? '1 : ((r_neg_a ^ r_neg_b) ? -r_lo : r_lo);
  assign w_rem  = r_neg_a ? -r_hi : r_hi;

  always_comb begin
    w_res = w_rem;
    case (r_funct3)
      3'd0:                w_res = w_prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    w_res = w_prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:          w_res = w_quo;
      default:             w_res = w_rem;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = w_early ? SIGN : CALC;
      CALC:    if (w_last) w_next = SIGN;
      SIGN:    w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (Flush_MD) w_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_funct3 <= '0;
      r_rd     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_wd     <= '0;
      r_waddr  <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_start) begin
          r_funct3 <= Funct3_MD;
          r_rd     <= Rd_MD;
          r_a      <= w_mag_a;
          r_b      <= w_mag_b;
          r_neg_a  <= w_neg_a;
          r_neg_b  <= w_neg_b;
          r_cnt    <= '0;
          if (w_early) begin
            // Preload the finished state: zero product/quotient, remainder = dividend.
            r_hi <= (w_is_div && (Rs2_MD == '0)) ? w_mag_a : '0;
            r_lo <= '0;
          end else begin
            r_hi <= '0;
            r_lo <= w_is_div ? w_mag_a : w_mag_b;
          end
        end
        CALC: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_funct3[2]) begin
            r_hi <= w_ge ? w_sub : w_rem_sh[XLEN-1:0];
            r_lo <= {r_lo[XLEN-2:0], w_ge};
          end else begin
            r_hi <= w_sum[XLEN:1];
            r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
          end
        end
        SIGN: if (!Flush_MD) begin
          r_wd    <= w_res;
          r_waddr <= r_rd;
        end
        default: ;
      endcase
    end
  end

  assign Busy_MD  = (r_state != IDLE);
  assign WrEn_MD  = (r_state == DONE) && (r_rd != 5'd0);
  assign WAddr_MD = r_waddr;
  assign WD_MD    = r_wd;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M vectors, latency, flush, restart and reset checks.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        Start_MD = 1'b0;
  logic        Flush_MD = 1'b0;
  logic [2:0]  Funct3_MD = '0;
  logic [31:0] Rs1_MD = '0;
  logic [31:0] Rs2_MD = '0;
  logic [4:0]  Rd_MD = '0;
  logic        Busy_MD, WrEn_MD;
  logic [4:0]  WAddr_MD;
  logic [31:0] WD_MD;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_t;

  wb_t exp_q[$];

  muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Start_MD  (Start_MD),
    .Flush_MD  (Flush_MD),
    .Funct3_MD (Funct3_MD),
    .Rs1_MD    (Rs1_MD),
    .Rs2_MD    (Rs2_MD),
    .Rd_MD     (Rd_MD),
    .Busy_MD   (Busy_MD),
    .WrEn_MD   (WrEn_MD),
    .WAddr_MD  (WAddr_MD),
    .WD_MD     (WD_MD)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write-back strobe is matched against the oldest expected entry.
  always @(negedge clk) begin
    wb_t e;
    if (rst_n && WrEn_MD === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_wb: actual addr=%0d data=0x%08h required no write", WAddr_MD, WD_MD);
      end else begin
        e = exp_q.pop_front();
        chk("wb_addr", {27'b0, WAddr_MD}, {27'b0, e.addr});
        chk("wb_data", WD_MD, e.data);
      end
    end
  end

  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                        input int restart_at, input int flush_at);
    int  lat, wr_cnt, wr_at, busy_end;
    bit  expect_wr;
    lat = 33;
`ifdef MULDIV_EARLY_OUT_EN
    if (a == 32'd0 || b == 32'd0) lat = 1;
`endif
    expect_wr = (rd != 5'd0) && (flush_at == 0);
    if (expect_wr) exp_q.push_back(wb_t'{addr: rd, data: exp});
    Funct3_MD = f3; Rs1_MD = a; Rs2_MD = b; Rd_MD = rd; Start_MD = 1'b1;
    @(posedge clk); #1;
    Start_MD = 1'b0;
    wr_cnt = 0; wr_at = 0; busy_end = 0;
    for (int k = 1; k <= 80 && busy_end == 0; k++) begin
      Start_MD = (k == restart_at);
      Flush_MD = (k == flush_at);
      if (k == restart_at) Rs1_MD = a ^ 32'h5;
      @(posedge clk); #1;
      if (WrEn_MD === 1'b1) begin
        wr_cnt++;
        wr_at = k;
      end
      if (Busy_MD === 1'b0) busy_end = k;
    end
    Start_MD = 1'b0;
    Flush_MD = 1'b0;
    chk({name, "_wr_count"}, wr_cnt, expect_wr ? 1 : 0);
    if (expect_wr) chk({name, "_wr_cycle"}, wr_at, lat);
    chk({name, "_busy_end"}, busy_end, (flush_at > 0) ? flush_at : lat + 1);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy",  {31'b0, Busy_MD}, 32'd0);
    chk("rst_wren",  {31'b0, WrEn_MD}, 32'd0);
    chk("rst_waddr", {27'b0, WAddr_MD}, 32'd0);
    chk("rst_wd",    WD_MD, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("mul",       3'd0, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 0, 0);
    run_op("mulhu",     3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'hFFFFFFFE, 0, 0);
    run_op("mulhsu",    3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFF, 0, 0);
    run_op("mulh",      3'd1, 32'h80000000, 32'h80000000, 5'd4,  32'h40000000, 0, 0);
    run_op("mulhu_16",  3'd3, 32'h00010000, 32'h00010000, 5'd6,  32'h00000001, 0, 0);
    run_op("div_neg",   3'd4, 32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFD, 0, 0);
    run_op("rem_neg",   3'd6, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFF, 0, 0);
    run_op("div_ovf",   3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h80000000, 0, 0);
    run_op("rem_ovf",   3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h00000000, 0, 0);
    run_op("divu_z",    3'd5, 32'd5,        32'd0,        5'd15, 32'hFFFFFFFF, 0, 0);
    run_op("remu_z",    3'd7, 32'd5,        32'd0,        5'd16, 32'h00000005, 0, 0);
    run_op("div_negz",  3'd4, 32'hFFFFFFFB, 32'd0,        5'd17, 32'hFFFFFFFF, 0, 0);
    run_op("rem_negz",  3'd6, 32'hFFFFFFFB, 32'd0,        5'd18, 32'hFFFFFFFB, 0, 0);
    run_op("mul_zero",  3'd0, 32'd0,        32'd9,        5'd19, 32'h00000000, 0, 0);
    run_op("divu_zero", 3'd5, 32'd0,        32'd3,        5'd20, 32'h00000000, 0, 0);
    run_op("remu",      3'd7, 32'd100,      32'd7,        5'd21, 32'd2,        0, 0);
    run_op("restart",   3'd0, 32'd3,        32'd5,        5'd12, 32'd15,       10, 0);
    run_op("flush15",   3'd4, 32'd100,      32'd7,        5'd13, 32'd14,       0, 15);
    run_op("flush33",   3'd7, 32'd100,      32'd7,        5'd14, 32'd2,        0, 33);
    run_op("rd0",       3'd0, 32'd3,        32'd4,        5'd0,  32'd12,       0, 0);
    run_op("divu",      3'd5, 32'd100,      32'd7,        5'd3,  32'd14,       0, 0);

    Funct3_MD = 3'd4; Rs1_MD = 32'hFFFFFF9C; Rs2_MD = 32'd7; Rd_MD = 5'd9; Start_MD = 1'b1;
    @(posedge clk); #1;
    Start_MD = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("prerst_busy", {31'b0, Busy_MD}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",  {31'b0, Busy_MD}, 32'd0);
    chk("mid_rst_wren",  {31'b0, WrEn_MD}, 32'd0);
    chk("mid_rst_waddr", {27'b0, WAddr_MD}, 32'd0);
    chk("mid_rst_wd",    WD_MD, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("mul_after_rst", 3'd0, 32'd3, 32'd4, 5'd7, 32'd12, 0, 0);

    @(negedge clk);
    chk("sb_drain", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide unit downstream of the register file. It takes the two read-port operands (RD1/RD2) plus funct3 and rd, and computes the result over multiple cycles. It returns a single-cycle write-back (address, data, enable) that the write-back mux routes to the register file write port. The pipeline stalls on Busy_MD.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.
CNT_W, 5, iteration counter width; must be at least clog2(XLEN).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
Start_MD  input  1  request; sampled only in IDLE
Flush_MD  input  1  abort current operation (pipeline kill)
Funct3_MD  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
Rs1_MD  input  XLEN  operand A (regfile RD1)
Rs2_MD  input  XLEN  operand B (regfile RD2)
Rd_MD  input  5  destination register
Busy_MD  output  1  high while state is not IDLE
WrEn_MD  output  1  one-cycle write-back strobe to regfile
WAddr_MD  output  5  write-back address
WD_MD  output  XLEN  write-back data

Behaviour:
- Reset (async, rst_n=0): state IDLE, counter 0, all internal registers 0; Busy_MD=0, WrEn_MD=0, WAddr_MD=0, WD_MD=0.
- FSM states are IDLE, CALC, SIGN, DONE. All outputs are driven from registers or decoded from state (Moore); there is no combinational path from inputs to outputs.
- IDLE: on an edge with Start_MD=1 and Flush_MD=0, latch funct3, rd, and operand magnitudes plus sign flags, clear the counter, and go to CALC.
  - Sign rules: MULH, DIV, and REM treat both operands as signed. MULHSU treats Rs1 as signed and Rs2 as unsigned. All other ops are unsigned.
- CALC: one radix-2 step per edge.
  - Multiply: shift-add into a 2*XLEN-bit accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - The counter increments each step; on the edge where counter = XLEN-1, go to SIGN.
- SIGN: one edge.
  - Apply two's-complement negation where required. Product is negated if the operand signs differ. Quotient is negated if signs differ. Remainder takes the dividend's sign.
  - Select the result: MUL takes the low XLEN bits; MULH/MULHSU/MULHU take the high XLEN bits; DIV/DIVU take the quotient; REM/REMU take the remainder.
  - Load WD_MD and WAddr_MD, then go to DONE.
- DONE: WrEn_MD=1 for exactly this one cycle, then IDLE on the next edge. WD_MD and WAddr_MD hold their values until the next SIGN.
- Latency: with Start sampled at edge E0, WrEn_MD is high in the cycle following edge E(XLEN+1), which is E33 for XLEN=32. Busy_MD is high from after E0 until edge E(XLEN+2).
- Start_MD is ignored while Busy_MD=1, including in DONE. There is no queueing.
- Rd_MD=0: the full latency still runs, but WrEn_MD stays 0 in DONE.
- Divide by zero: quotient = all ones; remainder = dividend. Same latency.
- Signed overflow (DIV with -2^(XLEN-1) / -1): quotient = -2^(XLEN-1), remainder = 0.
- Flush_MD=1 on any edge: next state is IDLE and no WrEn_MD is produced. Flush has priority over Start. A flush during DONE deasserts WrEn_MD from the next edge.
- rst_n asserted mid-operation: immediate return to the reset state; the operation is lost.

Optional Feature:
Macro MULDIV_EARLY_OUT_EN.
- Defined: in IDLE, when Start is accepted and Rs2_MD=0 (any op) or Rs1_MD=0 (any op), skip CALC and go directly to SIGN with the special-case result preloaded. WrEn_MD is then high in the cycle after E1, and Busy_MD lasts 2 cycles.
- Undefined: every operation takes the fixed XLEN+2-cycle latency.
- Results are identical in both builds.

Test Plan:
- MUL Rs1=7, Rs2=0xFFFFFFFD, Rd=5 -> WrEn_MD pulse in cycle after E33, WAddr_MD=5, WD_MD=0xFFFFFFEB; Busy_MD low after E34.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU Rs1=0xFFFFFFFF, Rs2=0xFFFFFFFF -> 0xFFFFFFFF; MULH 0x80000000*0x80000000 -> 0x40000000.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5. With MULDIV_EARLY_OUT_EN defined, the same ops give the same values with the pulse in the cycle after E1.
- Start pulsed again at E10 during a busy op -> ignored, exactly one WrEn_MD pulse. Flush_MD at E15 -> Busy_MD=0 after E15, no WrEn_MD. Rd_MD=0 -> no WrEn_MD.
- rst_n low asynchronously at cycle 20 of a DIV -> Busy_MD, WrEn_MD, WD_MD, and WAddr_MD all 0 immediately. A new MUL 3*4 after release -> 12 with normal latency.
